stream_cache_read_gate: RTL
===========================

Name: stream_cache_read_gate

Overview:
- Sits on the consumer side of the stream cache writer→reader token link, directly upstream of the read engine.
- Accepts byte-count tokens (`len`) from the writer's completed card writes and accumulates them into an "available bytes" credit counter.
- Holds each read request until the requested byte count is fully covered by credit, then issues it and debits the credit.
- Partially written regions are therefore never read.

Parameters:
- LEN_W, 32, width of token and request lengths in bytes (matches buffer_size_t).
- CNT_W, 40, width of the available-bytes credit counter; must be ≥ LEN_W+1.
- CAP_BYTES, 2**32, buffer capacity in bytes; requests larger than this are illegal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- link_len_data  in  LEN_W  bytes committed by the latest writer card write.
- link_len_valid  in  1  token valid.
- link_len_ready  out  1  token ready.
- req_len_data  in  LEN_W  bytes the read engine wants to read next.
- req_len_valid  in  1  request valid.
- req_len_ready  out  1  request ready.
- issue_len_data  out  LEN_W  granted request length.
- issue_len_valid  out  1  grant valid.
- issue_len_ready  in  1  grant ready.
- flush  in  1  synchronous pulse; clears credit and any pending request.
- avail_bytes  out  CNT_W  current credit (registered).
- err_oversize  out  1  sticky; set when a request exceeds CAP_BYTES.

Behaviour:
- Reset values (async on rst_n low): avail=0, state=IDLE, issue_len_valid=0, issue_len_data=0, req_len_ready=0, err_oversize=0, link_len_ready=0. Registers are released on the first clk edge after deassertion.
- Link input:
  - link_len_ready=1 whenever avail ≤ 2**CNT_W−1−(2**LEN_W−1), i.e. no overflow is possible. Otherwise 0 (backpressure).
  - Credit add on the handshake cycle; avail reflects it the next cycle.
- State machine:
  - IDLE: req_len_ready=1. On req handshake, latch len into pend.
    - If len > CAP_BYTES: set err_oversize, drop the request, stay IDLE.
    - Else go to WAIT.
  - WAIT: req_len_ready=0. When registered avail ≥ pend, go to ISSUE next cycle. len==0 passes WAIT in one cycle.
  - ISSUE: issue_len_valid=1, issue_len_data=pend, held stable until issue_len_ready. On handshake: debit pend from avail, clear valid, go to IDLE.
- Latency:
  - Credit handshake at cycle N covering a waiting request → issue_len_valid high at N+2.
  - Request arriving when credit already suffices → accepted N, WAIT N+1, issue N+2.
- Simultaneous add and debit in the same cycle: avail_next = avail + add − debit, computed at CNT_W bits. avail never underflows because debit ≤ avail by construction.
- At most one request is in flight; there is no request buffering beyond pend.
- flush has priority over everything in its cycle: avail=0, state=IDLE, issue_len_valid=0. A link token handshaken in the same cycle is discarded. err_oversize is not cleared by flush, only by reset.
- Reset mid-operation: all state is lost and pending grants vanish. The read engine must also be reset.
- Assertions (non-SYNTHESIS):
  - issue_len_data stable while valid && !ready.
  - No X on any valid or ready signal.
  - avail never decreases except on issue handshake or flush.

Optional Feature:
- STREAM_CACHE_GATE_STATS_EN: adds outputs stat_stall_cycles (32b, counts WAIT cycles), stat_tokens (32b, counts link handshakes) and stat_grants (32b, counts issue handshakes).
  - All counters saturate at 2**32−1 and clear on reset or flush.
- Without the macro these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared stream_cache_pkg:
  - buffer_size_t (LEN_W-bit logic).
  - credit_t (CNT_W-bit).
  - gate_state_t enum {IDLE, WAIT, ISSUE}.
  - CAP_BYTES default constant.
- One natural sub-module, stream_cache_credit_ctr: holds the add/debit/flush credit counter and the overflow-safe ready computation, exposing avail. The FSM stays in the top module.

Test Plan:
- Token 64 then request 64 → request accepted, issue_len_data=64 two cycles later, avail=0 after grant.
- Request 100 with avail=0, then tokens 40, 40, 40 → no grant until the third token; grant two cycles after it; avail=20 after grant.
- Token 32 handshaken in the same cycle as a grant of 16 with avail=16 → avail=32 next cycle.
- Request 200 exceeding CAP_BYTES=128 → err_oversize=1, no issue_len_valid, next legal request still served.
- Grant held with issue_len_ready=0 for 5 cycles → data stable, avail unchanged; then flush → valid drops, avail=0, state IDLE.
- Assert rst_n low while in ISSUE → issue_len_valid=0 and avail=0 immediately, independent of clk.

Source files
------------

// File: rtl/stream_cache_pkg.sv
// Shared types and defaults for the stream cache writer->reader token link.
package stream_cache_pkg;

    localparam int              SC_LEN_W     = 32;
    localparam int              SC_CNT_W     = 40;
    localparam longint unsigned SC_CAP_BYTES = 64'd1 << 32;
    localparam int              SC_STAT_W    = 32;

    typedef logic [SC_LEN_W-1:0] buffer_size_t;
    typedef logic [SC_CNT_W-1:0] credit_t;

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} gate_state_t;

    // Saturating increment for the optional statistics counters.
    function automatic logic [SC_STAT_W-1:0] sat_inc(input logic [SC_STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_cache_credit_ctr.sv
// Available-bytes credit counter: token adds, grant debits, flush clear, and
// an overflow-safe indication that one more maximum-size token still fits.
module stream_cache_credit_ctr #(
    parameter int LEN_W = 32,
    parameter int CNT_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             add_en,
    input  logic [LEN_W-1:0] add_len,
    input  logic             sub_en,
    input  logic [LEN_W-1:0] sub_len,
    output logic [CNT_W-1:0] avail,
    output logic             add_ok
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] MAX_TOK  = {{(CNT_W-LEN_W){1'b0}}, {LEN_W{1'b1}}};
    localparam logic [CNT_W-1:0] LIMIT    = ALL_ONES - MAX_TOK;

    logic [CNT_W-1:0] add_ext;
    logic [CNT_W-1:0] sub_ext;

    assign add_ext = add_en ? {{(CNT_W-LEN_W){1'b0}}, add_len} : '0;
    assign sub_ext = sub_en ? {{(CNT_W-LEN_W){1'b0}}, sub_len} : '0;

    // Any token may be accepted while the counter cannot wrap by adding it.
    assign add_ok = (avail <= LIMIT);

    // Credit update; flush wins over a same-cycle add or debit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            avail <= '0;
        else if (flush)
            avail <= '0;
        else
            avail <= avail + add_ext - sub_ext;
    end

endmodule

// File: rtl/stream_cache_read_gate.sv
// Read gate: holds each read request until committed credit covers it.
// Optional statistics outputs are built when STREAM_CACHE_GATE_STATS_EN is defined.
module stream_cache_read_gate
    import stream_cache_pkg::*;
#(
    parameter int              LEN_W     = SC_LEN_W,
    parameter int              CNT_W     = SC_CNT_W,
    parameter longint unsigned CAP_BYTES = SC_CAP_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] link_len_data,
    input  logic             link_len_valid,
    output logic             link_len_ready,
    input  logic [LEN_W-1:0] req_len_data,
    input  logic             req_len_valid,
    output logic             req_len_ready,
    output logic [LEN_W-1:0] issue_len_data,
    output logic             issue_len_valid,
    input  logic             issue_len_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] avail_bytes,
    output logic             err_oversize
`ifdef STREAM_CACHE_GATE_STATS_EN
    ,
    output logic [31:0]      stat_stall_cycles,
    output logic [31:0]      stat_tokens,
    output logic [31:0]      stat_grants
`endif
);

    gate_state_t      state_q, state_d;
    logic [LEN_W-1:0] pend_q, pend_d;
    logic             err_d;
    logic             en_q;
    logic             add_ok;
    logic             link_hs, req_hs, issue_hs;
    logic             oversize;

    // Handshake outputs stay low until the first clock after reset release.
    assign req_len_ready   = en_q && (state_q == IDLE);
    assign link_len_ready  = en_q && add_ok;
    assign issue_len_valid = (state_q == ISSUE);
    assign issue_len_data  = pend_q;

    assign link_hs  = link_len_valid && link_len_ready;
    assign req_hs   = req_len_valid && req_len_ready;
    assign issue_hs = issue_len_valid && issue_len_ready;
    assign oversize = 64'(req_len_data) > CAP_BYTES;

    stream_cache_credit_ctr #(.LEN_W(LEN_W), .CNT_W(CNT_W)) u_credit (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .add_en  (link_hs),
        .add_len (link_len_data),
        .sub_en  (issue_hs),
        .sub_len (pend_q),
        .avail   (avail_bytes),
        .add_ok  (add_ok)
    );

    // Next-state: accept -> wait for credit -> present grant; flush aborts.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = err_oversize;
        case (state_q)
            IDLE: if (req_hs) begin
                pend_d = req_len_data;
                if (oversize) err_d   = 1'b1;
                else          state_d = WAIT;
            end
            WAIT: if (avail_bytes >= {{(CNT_W-LEN_W){1'b0}}, pend_q}) state_d = ISSUE;
            ISSUE: if (issue_len_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pend_d  = pend_q;
            err_d   = err_oversize;
        end
    end

    // State, pending length, sticky error and output-enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            err_oversize <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            err_oversize <= err_d;
            en_q         <= 1'b1;
        end
    end

`ifdef STREAM_CACHE_GATE_STATS_EN
    // Saturating activity counters, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cycles <= '0;
            stat_tokens       <= '0;
            stat_grants       <= '0;
        end else if (flush) begin
            stat_stall_cycles <= '0;
            stat_tokens       <= '0;
            stat_grants       <= '0;
        end else begin
            if (state_q == WAIT) stat_stall_cycles <= sat_inc(stat_stall_cycles);
            if (link_hs)         stat_tokens       <= sat_inc(stat_tokens);
            if (issue_hs)        stat_grants       <= sat_inc(stat_grants);
        end
    end
`endif

`ifndef SYNTHESIS
    a_issue_stable: assert property (@(posedge clk) disable iff (!rst_n)
        issue_len_valid && !issue_len_ready |=> $stable(issue_len_data));
    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({link_len_valid, link_len_ready, req_len_valid, req_len_ready,
                     issue_len_valid, issue_len_ready}));
    a_avail_mono: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_hs || flush) |=> avail_bytes >= $past(avail_bytes));
`endif

endmodule
